// File: rtl/ika2151_phi_timing_gen.sv
// ika2151_phi_timing_gen
//   Timing front end for the core. Divides i_EMUCLK into active-low phi1
//   rising/falling clock enables and runs the operator slot counter. It also
//   produces the frame sync and a synchronised, phi1-aligned initial clear.
//
//   Parameters
//     DIV   : EMUCLK cycles per phi1 half-period, 1..255
//     SLOTS : slot counter modulus, a power of two in 2..32
//
//   Ports
//     i_EMUCLK     : sole clock, all flops on posedge
//     i_RST        : asynchronous active-high reset
//     i_IC_n       : external initial clear, asynchronous, active-low
//     o_PHI1PCEN_n : 1-EMUCLK low pulse at each phi1 rising edge
//     o_PHI1NCEN_n : 1-EMUCLK low pulse at each phi1 falling edge
//     o_PHI1       : phi1 level
//     o_CYCLE      : current slot, 0..SLOTS-1
//     o_SYNC       : high for one phi1 period while slot SLOTS-1 is current
//     o_IC_n       : internal initial clear, active-low, phi1-aligned
//
//   Build option
//     IKA2151_IC_STRETCH_EN : hold o_IC_n low for a full frame of PCEN edges
//     after the synchronised clear deasserts, so every slot sees IC.
module ika2151_phi_timing_gen #(
   parameter int DIV   = 2,
   parameter int SLOTS = 32
) (
   input  logic       i_EMUCLK,
   input  logic       i_RST,
   input  logic       i_IC_n,
   output logic       o_PHI1PCEN_n,
   output logic       o_PHI1NCEN_n,
   output logic       o_PHI1,
   output logic [4:0] o_CYCLE,
   output logic       o_SYNC,
   output logic       o_IC_n
);

   localparam logic [7:0] DIV_TERM  = 8'(DIV - 1);
   localparam logic [4:0] SLOT_LAST = 5'(SLOTS - 1);

   logic [7:0] r_div;
   logic       r_phase;
   logic [4:0] r_cyc;
   logic       r_sync;
   logic       r_ic_s1;
   logic       r_ic_s2;
   logic       r_ic_q;

   logic w_term;
   logic w_pcen;
   logic w_ncen;

   assign w_term = (r_div == DIV_TERM);
   assign w_pcen = w_term & ~r_phase;
   assign w_ncen = w_term &  r_phase;

   // The enables decode registered state, but with DIV=1 that decode is
   // already true while held in reset. Gating with i_RST keeps both enables
   // idle during reset and cuts an in-flight pulse the instant reset hits.
   assign o_PHI1PCEN_n = ~(w_pcen & ~i_RST);
   assign o_PHI1NCEN_n = ~(w_ncen & ~i_RST);
   assign o_PHI1       = r_phase;
   assign o_CYCLE      = r_cyc;
   assign o_SYNC       = r_sync;
   assign o_IC_n       = r_ic_q;

   // phi1 divider
   always_ff @(posedge i_EMUCLK or posedge i_RST) begin
      if (i_RST) begin
         r_div   <= 8'd0;
         r_phase <= 1'b0;
      end else if (w_term) begin
         r_div   <= 8'd0;
         r_phase <= ~r_phase;
      end else begin
         r_div   <= r_div + 8'd1;
      end
   end

   // Two-flop synchroniser for the asynchronous clear input
   always_ff @(posedge i_EMUCLK or posedge i_RST) begin
      if (i_RST) begin
         r_ic_s1 <= 1'b0;
         r_ic_s2 <= 1'b0;
      end else begin
         r_ic_s1 <= i_IC_n;
         r_ic_s2 <= r_ic_s1;
      end
   end

`ifdef IKA2151_IC_STRETCH_EN
   // Counts PCEN edges seen with the synchronised clear released; o_IC_n
   // lets go on the SLOTS-th such edge. Any re-assertion restarts the count.
   logic [5:0] r_str;

   always_ff @(posedge i_EMUCLK or posedge i_RST) begin
      if (i_RST) begin
         r_ic_q <= 1'b0;
         r_str  <= 6'd0;
      end else if (w_pcen) begin
         if (!r_ic_s2) begin
            r_ic_q <= 1'b0;
            r_str  <= 6'd0;
         end else if (!r_ic_q) begin
            if (r_str == 6'(SLOTS - 1)) r_ic_q <= 1'b1;
            r_str <= r_str + 6'd1;
         end
      end
   end
`else
   always_ff @(posedge i_EMUCLK or posedge i_RST) begin
      if (i_RST)       r_ic_q <= 1'b0;
      else if (w_pcen) r_ic_q <= r_ic_s2;
   end
`endif

   // Slot counter: clear takes priority over increment; wrap and clear both
   // land on 0.
   always_ff @(posedge i_EMUCLK or posedge i_RST) begin
      if (i_RST) begin
         r_cyc <= 5'd0;
      end else if (w_pcen) begin
         if (!r_ic_q || r_cyc == SLOT_LAST) r_cyc <= 5'd0;
         else                               r_cyc <= r_cyc + 5'd1;
      end
   end

   // Sync is sampled half a phi1 period after the slot changes.
   always_ff @(posedge i_EMUCLK or posedge i_RST) begin
      if (i_RST)       r_sync <= 1'b0;
      else if (w_ncen) r_sync <= r_ic_q & (r_cyc == SLOT_LAST);
   end

endmodule

// File: tb/tb_ika2151_phi_timing_gen.sv
// Testbench for ika2151_phi_timing_gen. Four instances with different DIV and
// SLOTS share one clock, reset and clear input. Each instance is compared
// every EMUCLK against a reference model. The model derives divider timing
// arithmetically from the count of edges since reset release.
module tb_ika2151_phi_timing_gen;

   localparam int NI = 4;

`ifdef IKA2151_IC_STRETCH_EN
   localparam bit STRETCH = 1'b1;
`else
   localparam bit STRETCH = 1'b0;
`endif

   function automatic int dv(input int k);
      case (k)
         0: return 2;
         1: return 1;
         2: return 255;
         default: return 3;
      endcase
   endfunction

   function automatic int sl(input int k);
      return (k == 3) ? 8 : 32;
   endfunction

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic ic_n = 1'b1;

   logic       pcn [NI];
   logic       ncn [NI];
   logic       phi [NI];
   logic [4:0] cyc [NI];
   logic       syn [NI];
   logic       icn [NI];

   always #5 clk = ~clk;

   for (genvar g = 0; g < NI; g++) begin : g_dut
      localparam int GD = (g == 0) ? 2 : (g == 1) ? 1 : (g == 2) ? 255 : 3;
      localparam int GS = (g == 3) ? 8 : 32;
      ika2151_phi_timing_gen #(.DIV(GD), .SLOTS(GS)) u_dut (
         .i_EMUCLK     (clk),
         .i_RST        (rst),
         .i_IC_n       (ic_n),
         .o_PHI1PCEN_n (pcn[g]),
         .o_PHI1NCEN_n (ncn[g]),
         .o_PHI1       (phi[g]),
         .o_CYCLE      (cyc[g]),
         .o_SYNC       (syn[g]),
         .o_IC_n       (icn[g])
      );
   end

   int n_tot = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input int got, input int exp);
      n_tot++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0d exp=%0d at %0t", tag, got, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // mn: EMUCLK edges since reset release. A PCEN edge is one where
   // mn mod 2*DIV == DIV-1; an NCEN edge is one where it equals 2*DIV-1.
   int   mn   [NI];
   int   mcyc [NI];
   int   msyn [NI];
   int   micq [NI];
   int   mstr [NI];
   logic mics1, mics2;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         mics1 <= 1'b0;
         mics2 <= 1'b0;
         for (int k = 0; k < NI; k++) begin
            mn[k] <= 0; mcyc[k] <= 0; msyn[k] <= 0; micq[k] <= 0; mstr[k] <= 0;
         end
      end else begin
         mics1 <= ic_n;
         mics2 <= mics1;
         for (int k = 0; k < NI; k++) begin
            if (mn[k] % (2 * dv(k)) == dv(k) - 1) begin
               mcyc[k] <= micq[k] ? (mcyc[k] + 1) % sl(k) : 0;
               if (!mics2) begin
                  micq[k] <= 0;
                  mstr[k] <= 0;
               end else if (micq[k] == 0) begin
                  if (mstr[k] + 1 >= (STRETCH ? sl(k) : 1)) micq[k] <= 1;
                  mstr[k] <= mstr[k] + 1;
               end
            end
            if (mn[k] % (2 * dv(k)) == 2 * dv(k) - 1)
               msyn[k] <= (micq[k] != 0 && mcyc[k] == sl(k) - 1) ? 1 : 0;
            mn[k] <= mn[k] + 1;
         end
      end
   end

   bit chk_en = 1'b0;

   always @(negedge clk) begin
      if (chk_en) begin
         for (int k = 0; k < NI; k++) begin
            int p;
            p = mn[k] % (2 * dv(k));
            if (rst) begin
               chk($sformatf("i%0d_rst_pcen", k), pcn[k], 1);
               chk($sformatf("i%0d_rst_ncen", k), ncn[k], 1);
               chk($sformatf("i%0d_rst_phi", k), phi[k], 0);
               chk($sformatf("i%0d_rst_cyc", k), cyc[k], 0);
               chk($sformatf("i%0d_rst_sync", k), syn[k], 0);
               chk($sformatf("i%0d_rst_ic", k), icn[k], 0);
            end else begin
               chk($sformatf("i%0d_pcen", k), pcn[k], (p == dv(k) - 1) ? 0 : 1);
               chk($sformatf("i%0d_ncen", k), ncn[k], (p == 2 * dv(k) - 1) ? 0 : 1);
               chk($sformatf("i%0d_phi", k), phi[k], (mn[k] / dv(k)) % 2);
               chk($sformatf("i%0d_cyc", k), cyc[k], mcyc[k]);
               chk($sformatf("i%0d_sync", k), syn[k], msyn[k]);
               chk($sformatf("i%0d_ic", k), icn[k], micq[k]);
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
      #2;
   endtask

   initial begin
      int w;
      rst  = 1'b1;
      ic_n = 1'b1;
      chk_en = 1'b1;
      cycles(4);
      rst = 1'b0;
      cycles(200);

      // Clear pulse of 10 EMUCLK launched while instance 0 is in slot 17
      w = 0;
      while (cyc[0] != 5'd17 && w < 2000) begin @(negedge clk); w++; end
      chk("wait_slot17", int'(w < 2000), 1);
      #2 ic_n = 1'b0;
      cycles(10);
      ic_n = 1'b1;
      cycles(300);

      // Random clear pulses, including sub-synchroniser glitches
      for (int i = 0; i < 30; i++) begin
         cycles($urandom_range(20, 300));
         ic_n = 1'b0;
         cycles($urandom_range(1, 60));
         ic_n = 1'b1;
      end

      // Three clean frames for instance 0
      cycles(400);

      // Asynchronous reset in the middle of a PCEN pulse at slot 9
      w = 0;
      while (!(cyc[0] == 5'd9 && pcn[0] == 1'b0) && w < 5000) begin
         @(negedge clk); w++;
      end
      chk("wait_slot9_pcen", int'(w < 5000), 1);
      #2 rst = 1'b1;
      #1;
      chk("async_pcen", pcn[0], 1);
      chk("async_cyc", cyc[0], 0);
      chk("async_phi", phi[0], 0);
      chk("async_ic", icn[0], 0);
      chk("async_sync", syn[0], 0);
      cycles(3);
      rst = 1'b0;

      // Long free run so the DIV=255 instance completes a frame
      cycles(17000);

      chk_en = 1'b0;
      $display("test done: total=%0d bad=%0d", n_tot, n_bad);
      $finish;
   end

endmodule
